// File: rtl/sha256d_block_sequencer.sv
// Block sequencer that time-shares one external SHA-256 compression unit across a
// multi-block pre-padded message, optionally finishing with the outer pass of a double hash.
`timescale 1ns/1ps

module sha256d_block_sequencer #(
    parameter int unsigned MAX_BLOCKS = 8,
    parameter bit          DOUBLE     = 1'b1,
    parameter int unsigned CNT_W      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] in_block,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] comp_data,
    output logic [255:0] comp_state,
    input  logic [255:0] comp_next_state,
    output logic [255:0] out_digest,
    output logic         out_err,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        ABSORB,
        FINAL,
        DONE
    } fsmState_e;

    localparam logic [255:0] H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    // Padding for a 32-byte message: 0x80 marker byte, zeros, bit length 256.
    localparam logic [255:0] PAD256 = {8'h80, 184'h0, 64'h100};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BLOCKS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    fsmState_e    fsm_q, fsm_d;
    logic [255:0] state_q, state_d;
    logic [CNT_W-1:0] blkCnt_q, blkCnt_d;
    logic [255:0] digest_q, digest_d;
    logic         err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= ABSORB;
            state_q  <= H0;
            blkCnt_q <= '0;
            digest_q <= '0;
            err_q    <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            blkCnt_q <= blkCnt_d;
            digest_q <= digest_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        blkCnt_d   = blkCnt_q;
        digest_d   = digest_q;
        err_d      = err_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        comp_data  = in_block;
        comp_state = state_q;

        case (fsm_q)
            ABSORB: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d  = comp_next_state;
                    blkCnt_d = (blkCnt_q == CNT_SAT) ? blkCnt_q : blkCnt_q + 1'b1;
                    if (in_last) begin
                        if (DOUBLE) begin
                            fsm_d = FINAL;
                        end else begin
                            digest_d = comp_next_state;
                            fsm_d    = DONE;
                        end
                    end else if (blkCnt_q == LAST_CNT) begin
                        // Overlong message: swallow the block and report an error instead.
                        err_d    = 1'b1;
                        digest_d = '0;
                        fsm_d    = DONE;
                    end
                end
            end
            FINAL: begin
                comp_data  = {state_q, PAD256};
                comp_state = H0;
                digest_d   = comp_next_state;
                fsm_d      = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d  = H0;
                    blkCnt_d = '0;
                    err_d    = 1'b0;
                    fsm_d    = ABSORB;
                end
            end
            default: begin
                fsm_d = ABSORB;
            end
        endcase
    end

    assign out_digest = digest_q;
    assign out_err    = err_q;
    assign busy       = !((fsm_q == ABSORB) && (blkCnt_q == '0));

endmodule

// File: tb/tb_sha256d_block_sequencer.sv
// Bench for sha256d_block_sequencer: two instances (single hash with MAX_BLOCKS=2, double hash
// with MAX_BLOCKS=8), each fed by a behavioural compression unit and checked against message hashes.
`timescale 1ns/1ps

module tb_sha256d_block_sequencer;

    localparam logic [255:0] H0 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] PAD256 = {8'h80, 184'd0, 64'h100};

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_EMPTY = {8'h80, 504'h0};
    localparam logic [511:0] BLK_TWO_A = {
        448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
        64'h8000000000000000};
    localparam logic [511:0] BLK_TWO_B = {448'h0, 64'h1c0};

    localparam logic [255:0] DIG_ABC    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_ABC_D  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
    localparam logic [255:0] DIG_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk;
    logic         rst;
    logic [511:0] inBlock   [2];
    logic         inLast    [2];
    logic         inValid   [2];
    logic         inReady   [2];
    logic [511:0] compData  [2];
    logic [255:0] compState [2];
    logic [255:0] compNext  [2];
    logic [255:0] outDigest [2];
    logic         outErr    [2];
    logic         outValid  [2];
    logic         outReady  [2];
    logic         busy      [2];

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    logic [511:0] msg [$];
    logic [511:0] blk;
    int nb;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 compression straight from the FIPS 180-4 round description.
    function automatic logic [255:0] sha256Compress(input logic [255:0] st, input logic [511:0] data);
        logic [31:0] w [64];
        logic [31:0] a, b, c, dd, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = data[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, dd, e, f, g, h} = st;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = dd + t1; dd = c; c = b; b = a; a = t1 + t2;
        end
        return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + dd,
                st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
    endfunction

    function automatic logic [255:0] modelHash(input logic [511:0] blocks [$], input bit dbl);
        logic [255:0] hv = H0;
        foreach (blocks[i]) hv = sha256Compress(hv, blocks[i]);
        if (dbl) hv = sha256Compress(H0, {hv, PAD256});
        return hv;
    endfunction

    assign compNext[0] = sha256Compress(compState[0], compData[0]);
    assign compNext[1] = sha256Compress(compState[1], compData[1]);

    sha256d_block_sequencer #(.MAX_BLOCKS(2), .DOUBLE(1'b0), .CNT_W(4)) dutSingle (
        .clk(clk), .rst(rst),
        .in_block(inBlock[0]), .in_last(inLast[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .comp_data(compData[0]), .comp_state(compState[0]), .comp_next_state(compNext[0]),
        .out_digest(outDigest[0]), .out_err(outErr[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .busy(busy[0]));

    sha256d_block_sequencer #(.MAX_BLOCKS(8), .DOUBLE(1'b1), .CNT_W(4)) dutDouble (
        .clk(clk), .rst(rst),
        .in_block(inBlock[1]), .in_last(inLast[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .comp_data(compData[1]), .comp_state(compState[1]), .comp_next_state(compNext[1]),
        .out_digest(outDigest[1]), .out_err(outErr[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .busy(busy[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one block and returns just after the edge that accepted it.
    task automatic applyStimulus(input int d, input logic [511:0] data, input logic last);
        int waited = 0;
        inBlock[d] = data;
        inLast[d]  = last;
        inValid[d] = 1'b1;
        while (!inReady[d] && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput("accept_ready", {511'd0, inReady[d]}, 512'd1);
        tick();
        inValid[d] = 1'b0;
    endtask

    // Waits for the result, checks it, then completes the output handshake.
    task automatic collectOutput(input int d, input string tag, input logic [255:0] expDigest,
                                 input logic expErr, input int holdCycles);
        int waited = 0;
        while (!outValid[d] && waited < 50) begin
            tick();
            waited++;
        end
        repeat (holdCycles) tick();
        checkOutput({tag, "_valid"}, {511'd0, outValid[d]}, 512'd1);
        checkOutput({tag, "_err"}, {511'd0, outErr[d]}, {511'd0, expErr});
        checkOutput({tag, "_digest"}, {256'd0, outDigest[d]}, {256'd0, expDigest});
        outReady[d] = 1'b1;
        tick();
        outReady[d] = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            inBlock[d] = '0; inLast[d] = 1'b0; inValid[d] = 1'b0; outReady[d] = 1'b0;
        end
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_in_ready", {511'd0, inReady[d]}, 512'd1);
            checkOutput("rst_out_valid", {511'd0, outValid[d]}, 512'd0);
            checkOutput("rst_out_err", {511'd0, outErr[d]}, 512'd0);
            checkOutput("rst_out_digest", {256'd0, outDigest[d]}, 512'd0);
            checkOutput("rst_busy", {511'd0, busy[d]}, 512'd0);
            checkOutput("rst_comp_state", {256'd0, compState[d]}, {256'd0, H0});
        end
        rst = 1'b0;
        tick();

        $display("[TB] single hash of abc, one edge latency");
        inBlock[0] = BLK_ABC; inLast[0] = 1'b1; inValid[0] = 1'b1;
        tick();
        inValid[0] = 1'b0;
        checkOutput("abc_valid_n", {511'd0, outValid[0]}, 512'd1);
        checkOutput("abc_digest", {256'd0, outDigest[0]}, {256'd0, DIG_ABC});
        checkOutput("abc_in_ready_done", {511'd0, inReady[0]}, 512'd0);
        checkOutput("abc_busy_done", {511'd0, busy[0]}, 512'd1);
        outReady[0] = 1'b1;
        tick();
        outReady[0] = 1'b0;
        checkOutput("abc_back_ready", {511'd0, inReady[0]}, 512'd1);
        checkOutput("abc_back_idle", {511'd0, busy[0]}, 512'd0);

        $display("[TB] double hash of abc, FINAL cycle then DONE");
        inBlock[1] = BLK_ABC; inLast[1] = 1'b1; inValid[1] = 1'b1;
        tick();
        inValid[1] = 1'b0;
        checkOutput("dabc_final_valid", {511'd0, outValid[1]}, 512'd0);
        checkOutput("dabc_final_ready", {511'd0, inReady[1]}, 512'd0);
        checkOutput("dabc_final_state", {256'd0, compState[1]}, {256'd0, H0});
        checkOutput("dabc_final_data", compData[1], {DIG_ABC, PAD256});
        tick();
        checkOutput("dabc_valid_n1", {511'd0, outValid[1]}, 512'd1);
        checkOutput("dabc_digest", {256'd0, outDigest[1]}, {256'd0, DIG_ABC_D});
        outReady[1] = 1'b1;
        tick();
        outReady[1] = 1'b0;

        $display("[TB] two-block message back to back");
        inBlock[0] = BLK_TWO_A; inLast[0] = 1'b0; inValid[0] = 1'b1;
        tick();
        checkOutput("two_mid_ready", {511'd0, inReady[0]}, 512'd1);
        checkOutput("two_mid_valid", {511'd0, outValid[0]}, 512'd0);
        checkOutput("two_mid_busy", {511'd0, busy[0]}, 512'd1);
        inBlock[0] = BLK_TWO_B; inLast[0] = 1'b1;
        tick();
        inValid[0] = 1'b0;
        collectOutput(0, "two", DIG_TWO, 1'b0, 0);

        $display("[TB] output stall with upstream pending");
        applyStimulus(0, BLK_ABC, 1'b1);
        inBlock[0] = BLK_EMPTY; inLast[0] = 1'b1; inValid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_in_ready", {511'd0, inReady[0]}, 512'd0);
            checkOutput("stall_valid", {511'd0, outValid[0]}, 512'd1);
            checkOutput("stall_digest", {256'd0, outDigest[0]}, {256'd0, DIG_ABC});
            tick();
        end
        outReady[0] = 1'b1;
        tick();
        outReady[0] = 1'b0;
        checkOutput("stall_release_ready", {511'd0, inReady[0]}, 512'd1);
        checkOutput("stall_release_valid", {511'd0, outValid[0]}, 512'd0);
        tick();
        inValid[0] = 1'b0;
        collectOutput(0, "stall_next", DIG_EMPTY, 1'b0, 0);

        $display("[TB] overflow of a two-block limit");
        blk = '0;
        for (int w = 0; w < 16; w++) blk[w*32 +: 32] = $urandom();
        applyStimulus(0, blk, 1'b0);
        checkOutput("ovf_first_valid", {511'd0, outValid[0]}, 512'd0);
        applyStimulus(0, ~blk, 1'b0);
        collectOutput(0, "ovf", 256'd0, 1'b1, 2);
        applyStimulus(0, BLK_EMPTY, 1'b1);
        collectOutput(0, "ovf_empty", DIG_EMPTY, 1'b0, 0);

        $display("[TB] reset in the middle of a message");
        applyStimulus(1, BLK_TWO_A, 1'b0);
        checkOutput("mid_busy", {511'd0, busy[1]}, 512'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_ready", {511'd0, inReady[1]}, 512'd1);
        checkOutput("mid_rst_valid", {511'd0, outValid[1]}, 512'd0);
        checkOutput("mid_rst_busy", {511'd0, busy[1]}, 512'd0);
        checkOutput("mid_rst_digest", {256'd0, outDigest[1]}, 512'd0);
        checkOutput("mid_rst_state", {256'd0, compState[1]}, {256'd0, H0});
        applyStimulus(1, BLK_ABC, 1'b1);
        collectOutput(1, "mid_rst_abc", DIG_ABC_D, 1'b0, 0);

        $display("[TB] eight-block limit on the double-hash instance");
        msg.delete();
        for (int b = 0; b < 8; b++) begin
            for (int w = 0; w < 16; w++) blk[w*32 +: 32] = $urandom();
            msg.push_back(blk);
            applyStimulus(1, blk, b == 7);
        end
        collectOutput(1, "max_legal", modelHash(msg, 1'b1), 1'b0, 1);
        for (int b = 0; b < 8; b++) begin
            for (int w = 0; w < 16; w++) blk[w*32 +: 32] = $urandom();
            applyStimulus(1, blk, 1'b0);
        end
        collectOutput(1, "max_ovf", 256'd0, 1'b1, 0);

        $display("[TB] randomized messages");
        for (int m = 0; m < 8; m++) begin
            for (int d = 0; d < 2; d++) begin
                nb = (d == 0) ? $urandom_range(1, 2) : $urandom_range(1, 8);
                msg.delete();
                for (int b = 0; b < nb; b++) begin
                    for (int w = 0; w < 16; w++) blk[w*32 +: 32] = $urandom();
                    msg.push_back(blk);
                    applyStimulus(d, blk, b == nb - 1);
                    if ($urandom_range(0, 3) == 0 && b != nb - 1) tick();
                end
                collectOutput(d, "rand", modelHash(msg, d == 1), 1'b0, $urandom_range(0, 3));
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sha256d_block_sequencer.md
Name: sha256d_block_sequencer

Overview:
Sequential controller that time-shares one combinational `sha256` compression instance, one compression per clock, across a multi-block preimage.
- Absorbs pre-padded 512-bit blocks from a valid/ready stream and chains the 256-bit state.
- Optionally runs the second (outer) SHA-256 pass of a double hash, then presents the digest on a valid/ready output.
- Replaces the unrolled chain of compression instances in sighash generation when area matters more than latency.

Parameters:
MAX_BLOCKS, 8, maximum blocks per message; any non-last block beyond this count aborts the message with an error.
DOUBLE, 1, 1 = output SHA256(SHA256(m)); 0 = output SHA256(m).
CNT_W, 4, block-counter width; must satisfy 2^CNT_W > MAX_BLOCKS.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_block  in  512  next pre-padded message block, MSB-first.
in_last  in  1  marks the final block of the message; qualified by in_valid.
in_valid  in  1  in_block/in_last are valid.
in_ready  out  1  block accepted on a cycle with in_valid & in_ready.
comp_data  out  512  data input to the shared compression unit.
comp_state  out  256  chaining-state input to the shared compression unit.
comp_next_state  in  256  combinational result from the compression unit, same cycle.
out_digest  out  256  result digest; zero when out_err = 1.
out_err  out  1  qualifies out_valid; message overflowed MAX_BLOCKS.
out_valid  out  1  digest/error available.
out_ready  in  1  consumer accepts on out_valid & out_ready.
busy  out  1  high whenever the FSM is not in ABSORB with blk_cnt = 0.

Behaviour:
- H0 = 6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19.
- PAD256 = 8000...0100 (256 bits: 0x80 leading byte, length 0x100 in the low bits).
- Registers: fsm, state_reg[255:0], blk_cnt[CNT_W-1:0], digest_reg[255:0], err_reg.

Reset (rst=1 at a clock edge, from any state, including mid-message):
- fsm = ABSORB, state_reg = H0, blk_cnt = 0, digest_reg = 0, err_reg = 0.
- Outputs: in_ready = 1, out_valid = 0, out_err = 0, out_digest = 0, busy = 0.
- A partially absorbed message is discarded.

ABSORB:
- Outputs: in_ready = 1, comp_data = in_block, comp_state = state_reg.
- On accept: state_reg <= comp_next_state, and blk_cnt <= blk_cnt + 1 (saturating).
- in_last = 1 and DOUBLE = 1: go to FINAL.
- in_last = 1 and DOUBLE = 0: digest_reg <= comp_next_state, go to DONE.
- in_last = 0 and blk_cnt = MAX_BLOCKS-1: err_reg <= 1, digest_reg <= 0, go to DONE. The block is consumed.
- No accept: hold all registers.

FINAL (one cycle):
- Outputs: in_ready = 0, comp_data = {state_reg, PAD256}, comp_state = H0.
- digest_reg <= comp_next_state, go to DONE.

DONE:
- Outputs: in_ready = 0, out_valid = 1, out_digest = digest_reg, out_err = err_reg.
- comp_data/comp_state are driven as in ABSORB; don't-care for the datapath.
- On out_ready: state_reg <= H0, blk_cnt <= 0, err_reg <= 0, go to ABSORB.
- The next block can be accepted in the cycle after out_ready. There is no same-cycle bypass.
- Outputs stay stable while out_ready = 0.

Latency (last block accepted at edge N):
- DOUBLE = 1: out_valid rises after edge N+1.
- DOUBLE = 0: out_valid rises after edge N.

Other rules:
- Throughput: one block per cycle while in ABSORB.
- Each message costs one bubble for FINAL plus one cycle for DONE.
- in_last on a one-block message is legal.
- in_valid while in FINAL/DONE is back-pressured: in_ready = 0, and the upstream must hold its data.
- The block does no padding of message blocks; the upstream supplies SHA-256-padded blocks.

Test Plan:
- Reset, then one block "abc" padded (61626380..0018) with in_last, DOUBLE=0 -> out_digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, out_valid one edge after accept.
- Same block, DOUBLE=1 -> 4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358, out_valid two edges after accept; comp_state = H0 during FINAL.
- Two-block padded "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", DOUBLE=0, back-to-back valid -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; in_ready stays 1 across both blocks.
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> in_ready=0, out_digest stable; raising out_ready returns to ABSORB and the next message hashes correctly from H0.
- MAX_BLOCKS=2, send 2 blocks without in_last -> out_valid=1, out_err=1, out_digest=0; after out_ready, empty-message block (80..00) DOUBLE=0 gives e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Assert rst for one cycle after the first of two blocks -> all outputs back to reset values; a fresh "abc" message then yields the correct digest.
